// File: rtl/sm_sum_collector.sv
// Sign-magnitude block accumulator: sums cfg_len samples (or fewer on flush)
// with per-step clamping to +/-(2^ACC_MAG - 1), then holds the total for a handshake.
module sm_sum_collector #(
  parameter int unsigned ACC_MAG = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8:0]         in_sum,
  input  logic [4:0]         cfg_len,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_MAG:0]   out_total,
  output logic [5:0]         out_count,
  output logic               out_sat
);

  localparam int unsigned AW = ACC_MAG + 2;
  localparam logic signed [AW-1:0] MAXV = AW'((1 << ACC_MAG) - 1);
  localparam logic signed [AW-1:0] MINV = -MAXV;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

  state_t                 r_state, w_next_state;
  logic signed [AW-1:0]   r_acc, w_acc_next;
  logic [5:0]             r_cnt, w_cnt_next;
  logic [5:0]             r_len, w_len_next;
  logic                   r_sat, w_sat_next;
  logic [ACC_MAG:0]       r_out_total;
  logic [5:0]             r_out_count;
  logic                   r_out_sat;

  logic                   w_accept;
  logic                   w_load_out;
  logic signed [AW-1:0]   w_mag;
  logic signed [AW-1:0]   w_sample;
  logic signed [AW-1:0]   w_sum;
  logic signed [AW-1:0]   w_clamped;
  logic                   w_clip;
  logic [5:0]             w_len;
  logic [5:0]             w_cnt_inc;
  logic                   w_neg;
  logic [ACC_MAG-1:0]     w_abs;

  assign in_ready  = (r_state != S_HOLD);
  assign out_valid = (r_state == S_HOLD);
  assign w_accept  = in_valid && in_ready;

  // -0 needs no special case: negating a zero magnitude yields zero
  assign w_mag     = {{(AW-8){1'b0}}, in_sum[7:0]};
  assign w_sample  = in_sum[8] ? -w_mag : w_mag;
  assign w_sum     = r_acc + w_sample;
  assign w_clip    = (w_sum > MAXV) || (w_sum < MINV);
  assign w_clamped = (w_sum > MAXV) ? MAXV : ((w_sum < MINV) ? MINV : w_sum);
  assign w_len     = (cfg_len == 5'd0) ? 6'd32 : {1'b0, cfg_len};
  assign w_cnt_inc = r_cnt + 6'd1;

  always_comb begin
    w_next_state = r_state;
    w_acc_next   = r_acc;
    w_cnt_next   = r_cnt;
    w_len_next   = r_len;
    w_sat_next   = r_sat;
    w_load_out   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_acc_next = w_sample;
          w_cnt_next = 6'd1;
          w_len_next = w_len;
          w_sat_next = 1'b0;
          if (w_len == 6'd1) begin
            w_next_state = S_HOLD;
            w_load_out   = 1'b1;
          end else begin
            w_next_state = S_ACCUM;
          end
        end
      end
      S_ACCUM: begin
        if (w_accept) begin
          w_acc_next = w_clamped;
          w_cnt_next = w_cnt_inc;
          w_sat_next = r_sat | w_clip;
        end
        if ((w_accept && (w_cnt_inc == r_len)) || flush) begin
          w_next_state = S_HOLD;
          w_load_out   = 1'b1;
        end
      end
      S_HOLD: begin
        if (out_ready) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // |acc| <= 2^ACC_MAG - 1, so negating only the low ACC_MAG bits is exact
  assign w_neg = w_acc_next[AW-1];
  assign w_abs = w_neg ? (~w_acc_next[ACC_MAG-1:0] + 1'b1) : w_acc_next[ACC_MAG-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_len       <= 6'd32;
      r_sat       <= 1'b0;
      r_out_total <= '0;
      r_out_count <= '0;
      r_out_sat   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_acc   <= w_acc_next;
      r_cnt   <= w_cnt_next;
      r_len   <= w_len_next;
      r_sat   <= w_sat_next;
      if (w_load_out) begin
        r_out_total <= {w_neg, w_abs};
        r_out_count <= w_cnt_next;
        r_out_sat   <= w_sat_next;
      end
    end
  end

  assign out_total = r_out_total;
  assign out_count = r_out_count;
  assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_sm_sum_collector.sv
// Scoreboard bench for sm_sum_collector: stimulus pushes block-level expected
// results, an independent monitor pops them when out_valid appears.
module tb_sm_sum_collector;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, flush, out_valid, out_ready, out_sat;
  logic [8:0]  in_sum;
  logic [4:0]  cfg_len;
  logic [12:0] out_total;
  logic [5:0]  out_count;

  always #5 clk = ~clk;

  sm_sum_collector #(.ACC_MAG(12)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .cfg_len(cfg_len), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_total(out_total), .out_count(out_count),
    .out_sat(out_sat)
  );

  typedef struct {
    logic [12:0] total;
    logic [5:0]  count;
    logic        sat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   rdy_hold = 0;
  bit   mon_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: decode each sample to an integer, add, clamp after every step.
  function automatic exp_t model(input logic [8:0] q[$]);
    exp_t e;
    int   acc = 0;
    bit   sat = 0;
    int   v;
    foreach (q[j]) begin
      v = q[j][8] ? -int'(q[j][7:0]) : int'(q[j][7:0]);
      acc += v;
      if (acc > 4095)  begin acc = 4095;  sat = 1; end
      if (acc < -4095) begin acc = -4095; sat = 1; end
    end
    e.total = {(acc < 0), 12'((acc < 0) ? -acc : acc)};
    e.count = 6'(q.size());
    e.sat   = sat;
    return e;
  endfunction

  // Monitor: owns out_ready, checks results and HOLD behaviour.
  initial begin
    bit   have = 0;
    bit   hs = 0;
    exp_t cur;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || !mon_en) begin
        have = 0; hs = 0; out_ready = 1'b0;
        continue;
      end
      if (hs) begin
        hs = 0; have = 0;
        chk("post_hs_out_valid", 32'(out_valid), 0);
        chk("post_hs_in_ready", 32'(in_ready), 1);
        out_ready = 1'($urandom_range(0, 1));
      end else if (out_valid) begin
        chk("hold_in_ready", 32'(in_ready), 0);
        if (!have) begin
          if (sb.size() == 0) begin
            chk("unexpected_out_valid", 32'(out_valid), 0);
            cur.total = out_total; cur.count = out_count; cur.sat = out_sat;
          end else begin
            cur = sb.pop_front();
          end
          have = 1;
        end
        chk("out_total", 32'(out_total), 32'(cur.total));
        chk("out_count", 32'(out_count), 32'(cur.count));
        chk("out_sat",   32'(out_sat),   32'(cur.sat));
        if (rdy_hold > 0) begin
          rdy_hold--;
          out_ready = 1'b0;
        end else begin
          out_ready = ($urandom_range(0, 2) != 0);
        end
        hs = out_ready;
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic drive_beat(input logic [8:0] s, input logic [4:0] cl, input logic fl, input bit first);
    int t = 0;
    in_valid = 1'b1; in_sum = s; cfg_len = cl; flush = fl;
    while (!in_ready) begin
      if (first) flush = 1'($urandom_range(0, 1));
      @(negedge clk);
      t++;
      if (t > 300) begin
        $display("FAIL in_ready_timeout actual=0 required=1 at %0t", $time);
        $fatal(1);
      end
    end
    @(negedge clk);
  endtask

  // fmode: 0 = full length, 1 = flush alone after last beat, 2 = flush with last beat
  task automatic run_block(input int len_cfg, input logic [8:0] vals[$], input int fmode);
    int n = vals.size();
    sb.push_back(model(vals));
    for (int i = 0; i < n; i++) begin
      drive_beat(vals[i],
                 (i == 0) ? 5'(len_cfg) : 5'($urandom),
                 (i == 0) ? 1'($urandom_range(0, 1)) : ((fmode == 2) && (i == n - 1)),
                 (i == 0));
      if ((i == n - 1) && (fmode != 1)) chk("latency_beat", 32'(out_valid), 1);
      in_valid = 1'b0; flush = 1'b0;
      if (i != n - 1) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    if (fmode == 1) begin
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("latency_flush", 32'(out_valid), 1);
    end
  endtask

  initial begin
    logic [8:0] q[$];
    int         t;
    rst_n = 1'b0; in_valid = 1'b0; in_sum = '0; cfg_len = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready",  32'(in_ready), 1);
    chk("rst_out_total", 32'(out_total), 0);
    chk("rst_out_count", 32'(out_count), 0);
    chk("rst_out_sat",   32'(out_sat), 0);
    rst_n = 1'b1;
    mon_en = 1;

    q = '{9'h00A, 9'h103, 9'h005};
    run_block(3, q, 0);
    q = {};
    for (int i = 0; i < 32; i++) q.push_back(9'h0FF);
    run_block(0, q, 0);
    q = '{9'h014, 9'h114};
    run_block(2, q, 0);
    q = '{9'h101, 9'h101, 9'h101, 9'h101};
    run_block(8, q, 1);

    rdy_hold = 5;
    q = '{9'h033};
    run_block(1, q, 0);
    q = '{9'h002, 9'h104};
    run_block(2, q, 0);

    // Reset mid-block: partial block must vanish
    drive_beat(9'h005, 5'd4, 1'b0, 1);
    in_valid = 1'b0; flush = 1'b0;
    drive_beat(9'h007, 5'd4, 1'b0, 0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("post_rst_in_ready",  32'(in_ready), 1);
    chk("post_rst_out_valid", 32'(out_valid), 0);
    chk("post_rst_out_count", 32'(out_count), 0);
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_no_valid", 32'(out_valid), 0);
    end
    q = '{9'h100};
    run_block(1, q, 0);

    for (int b = 0; b < 40; b++) begin
      int len_cfg = $urandom_range(0, 31);
      int L = (len_cfg == 0) ? 32 : len_cfg;
      int fmode = $urandom_range(0, 2);
      int n;
      bit same = 1'($urandom_range(0, 1));
      bit sg = 1'($urandom_range(0, 1));
      if (L < 2) fmode = 0;
      n = (fmode == 0) ? L : ((fmode == 1) ? $urandom_range(1, L - 1) : $urandom_range(2, L));
      q = {};
      for (int i = 0; i < n; i++) begin
        logic [8:0] s = 9'($urandom);
        if (same) s[8] = sg;
        q.push_back(s);
      end
      if ($urandom_range(0, 3) == 0) rdy_hold = $urandom_range(1, 4);
      run_block(len_cfg, q, fmode);
    end

    t = 0;
    while ((sb.size() != 0 || out_valid) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("scoreboard_drained", 32'(sb.size()), 0);
    chk("final_idle", 32'(out_valid), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
